ce_gen: RTL and testbench
=========================

CE_GEN -- requirements
Module: ce_gen

Interface
REQ-001 Parameter NCH, default 3: number of clock-enable channels, 1..16.
REQ-002 Parameter ACC_W, default 32: phase-accumulator width, 8..48.
REQ-003 Parameter LOCK_CYC, default 1024: consecutive synchronised-lock cycles required before run, 1..2^20.
REQ-004 Parameter INIT_INC, default 2^(ACC_W-1): reset increment loaded into every channel.
REQ-005 clkin  in  1  sole clock; all state on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pll_locked  in  1  PLL lock flag, asynchronous to clkin.
REQ-008 wr  in  1  increment write strobe.
REQ-009 wr_ch  in  4  target channel of write.
REQ-010 wr_inc  in  ACC_W  new increment value.
REQ-011 ch_en  in  NCH  per-channel strobe enable mask.
REQ-012 ce  out  NCH  one-cycle clock-enable strobes, registered.
REQ-013 ready  out  1  high while in RUN, registered.
REQ-014 rst_out  out  1  downstream synchronous reset; always equals !ready.
REQ-015 loss_cnt  out  8  count of lock losses while in RUN, saturating.

Function
REQ-016 pll_locked passes through a 2-flop synchroniser; lk denotes the second stage output.
REQ-017 States: WAIT_LOCK, STABLE, RUN; reset enters WAIT_LOCK.
REQ-018 WAIT_LOCK: lk=1 -> STABLE with lock counter cleared to 0; otherwise stay.
REQ-019 STABLE: lk=0 -> WAIT_LOCK; counter = LOCK_CYC-1 and lk=1 -> RUN; otherwise increment counter.
REQ-020 RUN: lk=0 -> WAIT_LOCK, loss_cnt += 1, saturating at 255; otherwise stay.
REQ-021 ready registers (next state == RUN), so ready rises in the first RUN cycle and falls in the first WAIT_LOCK cycle.
REQ-022 Every channel accumulator is held at 0 outside RUN; all channels therefore start phase-aligned on each RUN entry.
REQ-023 In RUN, each clock: acc[i] <= (acc[i] + inc[i]) mod 2^ACC_W; carry[i] = carry-out of that add.
REQ-024 ce[i] <= carry[i] & ch_en[i] & (state==RUN); ce is 0 whenever ready is 0.
REQ-025 Strobe rate: f_ce = f_clkin * inc / 2^ACC_W; inc=0 never strobes; inc=2^ACC_W-1 strobes on all cycles but one per 2^ACC_W.
REQ-026 ch_en=0 suppresses strobes only; the accumulator keeps advancing, so re-enabling preserves phase.
REQ-027 wr=1 with wr_ch<NCH: inc[wr_ch] <= wr_inc; the new value is used from the next cycle; acc is not cleared.
REQ-028 wr with wr_ch>=NCH is ignored; writes are accepted in any state.
REQ-029 With inc=2^(ACC_W-1): first ce 2 cycles after ready rises, then every 2 cycles; with inc=2^(ACC_W-2): first ce after 4 cycles, then every 4.

Reset
REQ-030 On rst: state=WAIT_LOCK, synchroniser=0, lock counter=0, acc=0, inc[i]=INIT_INC, ce=0, ready=0, rst_out=1, loss_cnt=0.
REQ-031 rst mid-RUN takes effect at the next edge; loss_cnt is cleared, not incremented.

Structure
REQ-032 Package ce_gen_pkg holds the state enum (WAIT_LOCK, STABLE, RUN) and the default ACC_W constant.
REQ-033 Sub-module ce_gen_ch implements one accumulator, increment register and ce flop; it is instantiated NCH times by generate.
REQ-034 The lock sequencer, synchroniser and loss counter live in ce_gen.

Verification
REQ-035 LOCK_CYC=16, pll_locked rises and stays high -> ready=1, rst_out=0 exactly 19 edges after the first edge sampling pll_locked high.
REQ-036 ACC_W=32, inc ch0=0x8000_0000, ch1=0x4000_0000, ch2=0 -> ch0 strobes every 2 cycles, ch1 every 4, ch2 never; ch0 and ch1 strobes coincide every 4 cycles.
REQ-037 pll_locked pulses low for 1 cycle during STABLE -> returns to WAIT_LOCK; ready rises LOCK_CYC+3 cycles after relock; loss_cnt=0.
REQ-038 pll_locked drops 300 times during RUN -> ce=0 and ready=0 within 3 cycles each time; loss_cnt=255.
REQ-039 During RUN, write wr_ch=1, wr_inc=0x2000_0000, then wr_ch=7 with NCH=3 -> ch1 period changes to 8 cycles without an acc reset; other channels are unaffected.
REQ-040 ch_en[0] cleared for 5 cycles and then restored -> the strobes that resume land on the original 2-cycle grid.

Source files
------------

// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg
//   Shared definitions for the ce_gen clock-enable generator.
//   - state_t   : lock sequencer states (WAIT_LOCK, STABLE, RUN)
//   - ACC_W_DEF : default phase-accumulator width
package ce_gen_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

endpackage

// File: rtl/ce_gen_if.sv
// ce_gen_if
//   Control/status bundle between a host and ce_gen.
//   Ports (signals):
//     wr       host -> gen  increment write strobe
//     wr_ch    host -> gen  target channel of the write
//     wr_inc   host -> gen  new increment value
//     ch_en    host -> gen  per-channel strobe enable mask
//     ce       gen  -> host one-cycle clock-enable strobes
//     ready    gen  -> host high while the sequencer is in RUN
//     rst_out  gen  -> host downstream synchronous reset (= !ready)
//     loss_cnt gen  -> host saturating count of lock losses seen in RUN
//
//   Handshake: wr is a single-cycle strobe with no back-pressure. Every
//   clkin edge that samples wr=1 is one complete write of wr_inc into
//   channel wr_ch; the generator is always ready to accept it, in any
//   state, and a wr_ch that names no channel is dropped silently.
interface ce_gen_if #(
  parameter int NCH   = 3,
  parameter int ACC_W = 32
);
  logic             wr;
  logic [3:0]       wr_ch;
  logic [ACC_W-1:0] wr_inc;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   ce;
  logic             ready;
  logic             rst_out;
  logic [7:0]       loss_cnt;

  modport master (
    output wr, wr_ch, wr_inc, ch_en,
    input  ce, ready, rst_out, loss_cnt
  );

  modport slave (
    input  wr, wr_ch, wr_inc, ch_en,
    output ce, ready, rst_out, loss_cnt
  );
endinterface

// File: rtl/ce_gen_ch.sv
// ce_gen_ch
//   One clock-enable channel: increment register, phase accumulator and
//   registered strobe flop. The strobe fires on the carry-out of the
//   accumulator add, so the strobe rate is f_clkin * inc / 2^ACC_W.
//   Ports:
//     clkin    clock
//     rst      synchronous active-high reset
//     run      sequencer is in RUN this cycle; accumulator advances
//     ce_gate  sequencer is in RUN and stays in RUN after this edge
//     en       strobe enable for this channel (accumulator unaffected)
//     wr       load wr_inc into the increment register
//     wr_inc   new increment value
//     ce       one-cycle clock-enable strobe
module ce_gen_ch #(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] INIT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             run,
  input  logic             ce_gate,
  input  logic             en,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // Extra top bit captures the carry-out of the modulo-2^ACC_W add.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clkin) begin
    if (rst) begin
      acc <= '0;
      inc <= INIT_INC;
      ce  <= 1'b0;
    end else begin
      if (wr) begin
        inc <= wr_inc;
      end
      // Held at zero outside RUN so every channel starts phase-aligned
      // on each RUN entry. Disabling the strobe never stops the phase.
      acc <= run ? sum[ACC_W-1:0] : '0;
      ce  <= sum[ACC_W] & en & ce_gate;
    end
  end

endmodule

// File: rtl/ce_gen.sv
// ce_gen
//   Multi-channel clock-enable generator gated by a PLL-lock sequencer.
//   pll_locked is synchronised (2 flops); the sequencer waits for a run
//   of LOCK_CYC consecutive synchronised-lock cycles in STABLE before
//   entering RUN. In RUN each of NCH phase accumulators emits a strobe
//   on its carry-out. Losing lock in RUN returns to WAIT_LOCK and bumps
//   a saturating loss counter.
//   Ports:
//     clkin       sole clock
//     rst         synchronous active-high reset
//     pll_locked  PLL lock flag, asynchronous to clkin
//     bus         ce_gen_if.slave: wr/wr_ch/wr_inc/ch_en in,
//                 ce/ready/rst_out/loss_cnt out
//     dbg_state   current sequencer state
module ce_gen
  import ce_gen_pkg::*;
#(
  parameter int               NCH      = 3,
  parameter int               ACC_W    = ACC_W_DEF,
  parameter int               LOCK_CYC = 1024,
  parameter logic [ACC_W-1:0] INIT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic    clkin,
  input  logic    rst,
  input  logic    pll_locked,
  ce_gen_if.slave bus,
  output state_t  dbg_state
);

  localparam int               CNT_W    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);

  logic [1:0]       sync_q;
  logic             lk;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic             ready_q;
  logic [7:0]       loss_q;
  logic             run;
  logic             ce_gate;
  logic [NCH-1:0]   wr_sel;
  logic [NCH-1:0]   ce_w;

  assign lk = sync_q[1];

  // Next-state decode; shared by the state register, ready and ce gating.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: begin
        if (lk) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lk)                       state_nxt = WAIT_LOCK;
        else if (lock_cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lk) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync_q   <= 2'b00;
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      ready_q  <= 1'b0;
      loss_q   <= 8'd0;
    end else begin
      sync_q  <= {sync_q[0], pll_locked};
      state   <= state_nxt;
      ready_q <= (state_nxt == RUN);
      // Counts STABLE cycles; any other path restarts it from zero,
      // which also covers the clear on WAIT_LOCK -> STABLE.
      if (state == STABLE && state_nxt == STABLE) begin
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
      if (state == RUN && !lk && loss_q != 8'hff) begin
        loss_q <= loss_q + 8'd1;
      end
    end
  end

  assign run = (state == RUN);
  // The strobe flop only loads a 1 when RUN is kept across the edge, so
  // a strobe can never appear alongside ready=0 on the exit cycle.
  assign ce_gate = run && (state_nxt == RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // wr_ch is 4 bits and NCH <= 16; codes >= NCH match no channel.
    assign wr_sel[i] = bus.wr && (bus.wr_ch == 4'(i));

    ce_gen_ch #(
      .ACC_W    (ACC_W),
      .INIT_INC (INIT_INC)
    ) u_ch (
      .clkin   (clkin),
      .rst     (rst),
      .run     (run),
      .ce_gate (ce_gate),
      .en      (bus.ch_en[i]),
      .wr      (wr_sel[i]),
      .wr_inc  (bus.wr_inc),
      .ce      (ce_w[i])
    );
  end

  assign bus.ce       = ce_w;
  assign bus.ready    = ready_q;
  assign bus.rst_out  = ~ready_q;
  assign bus.loss_cnt = loss_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_ce_gen.sv
module tb_ce_gen;
  import ce_gen_pkg::*;

  localparam int NCH      = 3;
  localparam int ACC_W    = 32;
  localparam int LOCK_CYC = 16;
  localparam int EW       = 8 + 1 + NCH;

  // ---------------- clock / reset ----------------
  logic   clkin      = 1'b0;
  logic   rst        = 1'b1;
  logic   pll_locked = 1'b0;
  state_t dbg_state;

  always #5 clkin = ~clkin;

  ce_gen_if #(.NCH(NCH), .ACC_W(ACC_W)) bus ();

  ce_gen #(
    .NCH      (NCH),
    .ACC_W    (ACC_W),
    .LOCK_CYC (LOCK_CYC)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .pll_locked (pll_locked),
    .bus        (bus),
    .dbg_state  (dbg_state)
  );

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int k_run    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ready after an edge: the synchronised lock has been high for at least
  // LOCK_CYC+1 consecutive samples; lk lags pll_locked by two samples, so
  // use the pll_locked streak as it stood two edges earlier.
  // Channel phase: an unbounded running sum of increments; a strobe is due
  // whenever the sum crosses a multiple of 2^ACC_W.
  logic [EW-1:0]    exp_q[$];
  logic             m_valid = 1'b0;
  int               s0, s1, s2;
  logic             m_ready;
  logic             m_was_run;
  logic             m_lk;
  logic [7:0]       m_loss;
  logic [NCH-1:0]   m_ce;
  longint unsigned  ph[NCH];
  longint unsigned  nph;
  logic [ACC_W-1:0] inc_m[NCH];

  always @(posedge clkin) begin
    if (rst) begin
      m_valid = 1'b1;
      s0 = 0; s1 = 0; s2 = 0;
      m_ready = 1'b0;
      m_loss  = 8'd0;
      m_ce    = '0;
      for (int i = 0; i < NCH; i++) begin
        ph[i]    = 0;
        inc_m[i] = 32'h8000_0000;
      end
      exp_q.push_back({m_loss, m_ready, m_ce});
    end else if (m_valid) begin
      m_was_run = m_ready;
      s2 = s1;
      s1 = s0;
      s0 = pll_locked ? s0 + 1 : 0;
      m_lk    = (s2 != 0);
      m_ready = (s2 >= LOCK_CYC + 1);
      if (m_was_run && !m_lk && m_loss < 8'd255) m_loss = m_loss + 8'd1;
      for (int i = 0; i < NCH; i++) begin
        if (m_was_run) begin
          nph     = ph[i] + longint'(inc_m[i]);
          m_ce[i] = ((nph >> ACC_W) != (ph[i] >> ACC_W)) && bus.ch_en[i] && m_ready;
          ph[i]   = nph;
        end else begin
          ph[i]   = 0;
          m_ce[i] = 1'b0;
        end
      end
      if (bus.wr && bus.wr_ch < NCH) inc_m[bus.wr_ch] = bus.wr_inc;
      exp_q.push_back({m_loss, m_ready, m_ce});
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [EW-1:0] e;
  always @(negedge clkin) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_ce",      bus.ce,              e[NCH-1:0]);
      check("sb_ready",   bus.ready,           e[NCH]);
      check("sb_rst_out", bus.rst_out,         !e[NCH]);
      check("sb_state",   (dbg_state == RUN),  e[NCH]);
      check("sb_loss",    bus.loss_cnt,        e[EW-1:NCH+1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clkin);
    #1;
    k_run++;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (bus.ready) break;
    end
  endtask

  task automatic write_inc(input int ch, input logic [ACC_W-1:0] v);
    bus.wr     = 1'b1;
    bus.wr_ch  = 4'(ch);
    bus.wr_inc = v;
    tick();
    bus.wr     = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int n;
  logic [NCH-1:0] exp_ce;

  initial begin
    bus.wr     = 1'b0;
    bus.wr_ch  = 4'd0;
    bus.wr_inc = '0;
    bus.ch_en  = '1;

    // reset state
    tick();
    tick();
    check("rst_ready",   bus.ready,    1'b0);
    check("rst_rst_out", bus.rst_out,  1'b1);
    check("rst_ce",      bus.ce,       3'b000);
    check("rst_loss",    bus.loss_cnt, 8'd0);
    check("rst_state",   dbg_state,    WAIT_LOCK);
    rst = 1'b0;

    // increments: ch0 keeps 0x8000_0000, ch1 = 0x4000_0000, ch2 = 0
    write_inc(1, 32'h4000_0000);
    write_inc(2, 32'h0000_0000);

    // lock acquisition: ready 19 edges after the first edge seeing lock
    pll_locked = 1'b1;
    wait_ready(n);
    check("lock_time", n, 19);
    check("lock_rst_out", bus.rst_out, 1'b0);

    // strobe grid: ch0 every 2, ch1 every 4, ch2 never
    k_run = 0;
    while (k_run < 16) begin
      tick();
      exp_ce = {1'b0, (k_run % 4 == 0), (k_run % 2 == 0)};
      check("grid", bus.ce, exp_ce);
    end

    // ch0 disabled for 5 cycles, then back on the same even grid
    bus.ch_en = 3'b110;
    repeat (5) begin
      tick();
      exp_ce = {1'b0, (k_run % 4 == 0), 1'b0};
      check("ch0_off", bus.ce, exp_ce);
    end
    bus.ch_en = 3'b111;
    while (k_run < 24) begin
      tick();
      exp_ce = {1'b0, (k_run % 4 == 0), (k_run % 2 == 0)};
      check("ch0_resume", bus.ce, exp_ce);
    end

    // live increment change on ch1 (acc=0 at k=24): new period 8 with
    // first strobe at k=31; write to channel 7 is dropped
    while (k_run < 48) begin
      if (k_run == 24) begin
        bus.wr = 1'b1; bus.wr_ch = 4'd1; bus.wr_inc = 32'h2000_0000;
      end else if (k_run == 25) begin
        bus.wr_ch = 4'd7; bus.wr_inc = 32'h1234_5678;
      end else begin
        bus.wr = 1'b0;
      end
      tick();
      exp_ce = {1'b0, (k_run == 31 || k_run == 39 || k_run == 47), (k_run % 2 == 0)};
      check("inc_change", bus.ce, exp_ce);
    end
    bus.wr = 1'b0;

    // 300 lock losses from RUN; loss counter saturates
    for (int d = 0; d < 300; d++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      check("drop_out", {bus.ready, bus.ce}, 4'b0000);
      pll_locked = 1'b1;
      wait_ready(n);
      check("relock_time", n, 19);
    end
    check("loss_sat", bus.loss_cnt, 8'd255);

    // reset mid-RUN clears the loss counter without counting a loss
    rst = 1'b1;
    tick();
    check("midrst_loss",    bus.loss_cnt, 8'd0);
    check("midrst_ready",   bus.ready,    1'b0);
    check("midrst_rst_out", bus.rst_out,  1'b1);
    check("midrst_ce",      bus.ce,       3'b000);
    rst = 1'b0;

    // one-cycle lock glitch in STABLE restarts the count
    repeat (6) tick();
    check("stable_state", dbg_state, STABLE);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_ready(n);
    check("glitch_relock", n, LOCK_CYC + 3);
    check("glitch_loss", bus.loss_cnt, 8'd0);

    repeat (8) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
